if_fetch_buf: RTL and testbench

//  Decoupled instruction-fetch front end for the RV64 core.

---
 rtl/if_fetch_buf.sv | 157 +++++++++++++++
 tb/tb_if_fetch_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_buf
//  Description : Decoupled instruction-fetch front end. Issues in-order reads
//                on a req/gnt/rvalid memory port, buffers returned words with
//                their PCs in a small circular FIFO and presents them to
//                decode over a valid/ready handshake. Redirects from execute
//                re-target fetch, flush the buffer and mark every in-flight
//                response as stale so it is discarded on return.
//  Ports       : clk            core clock, all state on posedge
//                rst            asynchronous active-low reset
//                redirect_valid redirect request from execute
//                redirect_pc    redirect target (bits [1:0] forced to 0)
//                imem_req/addr  fetch request and address
//                imem_gnt       request accepted
//                imem_rvalid    read data valid (one per grant, in order)
//                imem_rdata     returned instruction word
//                id_valid/ready decode handshake
//                id_pc/id_inst  presented PC and instruction
//  Options     : IF_BYPASS_EN - when defined, a kept response arriving while
//                the buffer is empty and decode is ready is presented in the
//                same cycle instead of being written to the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_buf #(
   parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [63:0] id_pc,
   output logic [31:0] id_inst
);

   localparam int                c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                c_CNT_W = $clog2(DEPTH + 1);
   localparam logic [c_CNT_W:0]  c_DEPTH = (c_CNT_W + 1)'(DEPTH);

   logic [63:0]          r_fetch_pc;
   logic [63:0]          r_resp_pc;
   logic [c_CNT_W-1:0]   r_inflight;
   logic [c_CNT_W-1:0]   r_drop_cnt;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [63:0]          r_fifo_pc   [DEPTH];
   logic [31:0]          r_fifo_inst [DEPTH];

   logic                 w_credit_ok;
   logic                 w_req;
   logic                 w_grant;
   logic                 w_drop;
   logic                 w_keep;
   logic                 w_fifo_ne;
   logic                 w_bypass;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_id_valid;
   logic [c_CNT_W-1:0]   w_inflight_next;

   // Buffered plus outstanding fetches never exceed DEPTH, so every response
   // is guaranteed a free slot. Pops in the current cycle are not credited.
   assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_count}) < c_DEPTH;
   assign w_req       = rst & ~redirect_valid & w_credit_ok;
   assign w_grant     = w_req & imem_gnt;
   assign w_drop      = (r_drop_cnt != '0);
   assign w_keep      = imem_rvalid & ~w_drop & ~redirect_valid;
   assign w_fifo_ne   = (r_count != '0);

`ifdef IF_BYPASS_EN
   assign w_bypass    = rst & w_keep & ~w_fifo_ne & id_ready;
`else
   assign w_bypass    = 1'b0;
`endif

   assign w_push      = w_keep & ~w_bypass;
   assign w_id_valid  = rst & ~redirect_valid & (w_fifo_ne | w_bypass);
   assign w_pop       = w_id_valid & id_ready & w_fifo_ne;

   // Outstanding count after this cycle's grant/return; on a redirect it is
   // also the number of responses still to come that must be discarded.
   assign w_inflight_next = r_inflight + c_CNT_W'(w_grant) - c_CNT_W'(imem_rvalid);

   assign imem_req  = w_req;
   assign imem_addr = r_fetch_pc;
   assign id_valid  = w_id_valid;

`ifdef IF_BYPASS_EN
   assign id_pc   = w_bypass  ? r_resp_pc  :
                    w_fifo_ne ? r_fifo_pc[r_rd_ptr] : 64'h0;
   assign id_inst = w_bypass  ? imem_rdata :
                    w_fifo_ne ? r_fifo_inst[r_rd_ptr] : 32'h0;
`else
   assign id_pc   = w_fifo_ne ? r_fifo_pc[r_rd_ptr]   : 64'h0;
   assign id_inst = w_fifo_ne ? r_fifo_inst[r_rd_ptr] : 32'h0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= PC_START;
         r_resp_pc  <= PC_START;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= {redirect_pc[63:2], 2'b00};
         r_resp_pc  <= {redirect_pc[63:2], 2'b00};
         r_inflight <= w_inflight_next;
         r_drop_cnt <= w_inflight_next;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + 64'd4;
         end
         r_inflight <= w_inflight_next;
         if (imem_rvalid && w_drop) begin
            r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
         end
         if (w_keep) begin
            r_resp_pc <= r_resp_pc + 64'd4;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   // Payload storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
         r_fifo_inst[r_wr_ptr] <= imem_rdata;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
                                    !(imem_rvalid && ({1'b0, r_count} == c_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_buf
//  Description : Directed, table-driven testbench for if_fetch_buf
//                (DEPTH = 2, PC_START = 0x8000_0000). Each table row gives
//                one cycle of inputs and the expected combinational outputs
//                for that cycle; hand-written sequences cover bypass and a
//                mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_buf;

   localparam logic [63:0] P = 64'h0000_0000_8000_0000;
   localparam int          c_NVEC = 25;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [63:0] id_pc;
   logic [31:0] id_inst;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rv;
      logic [63:0] rpc;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_val;
      logic [63:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t tbl [c_NVEC];

   if_fetch_buf #(
      .PC_START (P),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_inst        (id_inst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [63:0] rpc, input logic g,
                        input logic rvl, input logic [31:0] rd, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_gnt       = g;
      imem_rvalid    = rvl;
      imem_rdata     = rd;
      id_ready       = rdy;
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [63:0] addr,
                             input logic val, input logic [63:0] pc, input logic [31:0] inst);
      chk({tag, ".imem_req"},  {63'h0, imem_req}, {63'h0, req});
      chk({tag, ".imem_addr"}, imem_addr, addr);
      chk({tag, ".id_valid"},  {63'h0, id_valid}, {63'h0, val});
      chk({tag, ".id_pc"},     id_pc, pc);
      chk({tag, ".id_inst"},   {32'h0, id_inst}, {32'h0, inst});
   endtask

   initial begin
      //          rv    rpc                     gnt   rvl   rdata          rdy  | req  addr                    val   pc                      inst
      // Fill and stream with 1-cycle memory, decode always ready.
      tbl[0]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, P,                      1'b0, 64'h0,                  32'h0};
      tbl[1]  = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h1000_0000, 1'b1, 1'b1, P + 64'h04,             1'b0, 64'h0,                  32'h0};
      tbl[2]  = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h1000_0001, 1'b1, 1'b0, P + 64'h08,             1'b1, P,                      32'h1000_0000};
      tbl[3]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, P + 64'h08,             1'b1, P + 64'h04,             32'h1000_0001};
      tbl[4]  = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h1000_0002, 1'b1, 1'b1, P + 64'h0C,             1'b0, 64'h0,                  32'h0};
      tbl[5]  = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h1000_0003, 1'b1, 1'b0, P + 64'h10,             1'b1, P + 64'h08,             32'h1000_0002};
      // Decode stalls: fill to DEPTH, request drops, then drain in order.
      tbl[6]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, P + 64'h10,             1'b1, P + 64'h0C,             32'h1000_0003};
      tbl[7]  = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h1000_0004, 1'b0, 1'b0, P + 64'h14,             1'b1, P + 64'h0C,             32'h1000_0003};
      tbl[8]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, P + 64'h14,             1'b1, P + 64'h0C,             32'h1000_0003};
      tbl[9]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, P + 64'h14,             1'b1, P + 64'h0C,             32'h1000_0003};
      tbl[10] = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b1, 1'b0, P + 64'h14,             1'b1, P + 64'h0C,             32'h1000_0003};
      tbl[11] = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, P + 64'h14,             1'b1, P + 64'h10,             32'h1000_0004};
      // Two fetches in flight, redirect to P+0x100; both stale words dropped.
      tbl[12] = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, P + 64'h18,             1'b0, 64'h0,                  32'h0};
      tbl[13] = '{1'b1, P + 64'h100,            1'b1, 1'b0, 32'h0,         1'b1, 1'b0, P + 64'h1C,             1'b0, 64'h0,                  32'h0};
      tbl[14] = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, P + 64'h100,            1'b0, 64'h0,                  32'h0};
      tbl[15] = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'hDEAD_0002, 1'b1, 1'b1, P + 64'h100,            1'b0, 64'h0,                  32'h0};
      tbl[16] = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h2000_0000, 1'b1, 1'b1, P + 64'h104,            1'b0, 64'h0,                  32'h0};
      tbl[17] = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h2000_0001, 1'b1, 1'b0, P + 64'h108,            1'b1, P + 64'h100,            32'h2000_0000};
      tbl[18] = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, P + 64'h108,            1'b1, P + 64'h104,            32'h2000_0001};
      // Redirect together with rvalid and ready: word dropped, no pop, flush;
      // target 0x...FE aligns to 0x...FC and the next fetch wraps to 0.
      tbl[19] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 32'hDEAD_0003, 1'b1, 1'b0, P + 64'h10C,         1'b0, P + 64'h104,            32'h2000_0001};
      tbl[20] = '{1'b0, 64'h0,                  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0,                 32'h0};
      tbl[21] = '{1'b0, 64'h0,                  1'b1, 1'b1, 32'h3000_0000, 1'b1, 1'b1, 64'h0,                  1'b0, 64'h0,                  32'h0};
      tbl[22] = '{1'b0, 64'h0,                  1'b0, 1'b1, 32'h3000_0001, 1'b1, 1'b0, 64'h4,                  1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h3000_0000};
      tbl[23] = '{1'b0, 64'h0,                  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h4,                  1'b1, 64'h0,                  32'h3000_0001};
      tbl[24] = '{1'b0, 64'h0,                  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h4,                  1'b0, 64'h0,                  32'h0};

      // Reset state while rst is held low.
      repeat (2) @(negedge clk);
      #1;
      expect_out("reset", 1'b0, P, 1'b0, 64'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;

`ifndef IF_BYPASS_EN
      for (int i = 0; i < c_NVEC; i++) begin
         drive(tbl[i].rv, tbl[i].rpc, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].rdy);
         #1;
         expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                    tbl[i].e_val, tbl[i].e_pc, tbl[i].e_inst);
         @(negedge clk);
      end
`else
      // Bypass: a kept word with an empty buffer and ready decode is
      // presented in the rvalid cycle.
      drive(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1; expect_out("byp0", 1'b1, P, 1'b0, 64'h0, 32'h0);
      @(negedge clk);
      drive(1'b0, 64'h0, 1'b1, 1'b1, 32'h4000_0000, 1'b1);
      #1; expect_out("byp1", 1'b1, P + 64'h04, 1'b1, P, 32'h4000_0000);
      @(negedge clk);
      drive(1'b0, 64'h0, 1'b1, 1'b1, 32'h4000_0001, 1'b1);
      #1; expect_out("byp2", 1'b1, P + 64'h08, 1'b1, P + 64'h04, 32'h4000_0001);
      @(negedge clk);
      drive(1'b0, 64'h0, 1'b0, 1'b1, 32'h4000_0002, 1'b0);
      #1; expect_out("byp3", 1'b1, P + 64'h0C, 1'b0, 64'h0, 32'h0);
      @(negedge clk);
      drive(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1; expect_out("byp4", 1'b1, P + 64'h0C, 1'b1, P + 64'h08, 32'h4000_0002);
      @(negedge clk);
`endif

      // Mid-operation reset: a grant is taken, then reset clears everything
      // immediately.
      drive(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      expect_out("midrst", 1'b0, P, 1'b0, 64'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      expect_out("postrst", 1'b1, P, 1'b0, 64'h0, 32'h0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
